// File: rtl/trace_capture_pkg.sv
// Shared types and constants for the CPU trace capture block.
package trace_capture_pkg;

   localparam int unsigned TW_DEFAULT    = 36;
   localparam int unsigned DEPTH_DEFAULT = 16;
   localparam int unsigned DROP_W        = 16;
   localparam logic [DROP_W-1:0] DROP_MAX = 16'hFFFF;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/trace_capture_fifo.sv
// Plain synchronous FIFO: registered storage, head read from memory, no policy.
// Caller must never push when full without a same-cycle pop, nor pop when empty.
module trace_capture_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned TW    = 36
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   i_push,
   input  logic [TW-1:0]          i_data,
   input  logic                   i_pop,
   output logic [TW-1:0]          o_head,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [TW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_level;

   // Storage has no reset; only pointers and level define validity.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_level <= r_level + LW'(i_push) - LW'(i_pop);
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_level = r_level;

endmodule

// File: rtl/trace_capture.sv
// CPU trace capture: buffers trace words, stops accepting on trap, then drains
// the captured words and reports completion. Drops on full are counted.
module trace_capture
   import trace_capture_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT,
   parameter int unsigned TW    = TW_DEFAULT
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   trace_valid,
   input  logic [TW-1:0]          trace_data,
   input  logic                   trap,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [TW-1:0]          out_data,
   output logic                   out_last,
   output logic                   done,
   output logic                   overflow,
   output logic [DROP_W-1:0]      drop_count,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned LW = $clog2(DEPTH) + 1;

   state_e            r_state;
   state_e            w_state_nxt;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop_count;
   logic [LW-1:0]     w_level;
   logic [LW-1:0]     w_level_nxt;
   logic              w_full;
   logic              w_pop;
   logic              w_push;
   logic              w_drop;
   logic              w_run;

   trace_capture_fifo #(
      .DEPTH (DEPTH),
      .TW    (TW)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_push),
      .i_data  (trace_data),
      .i_pop   (w_pop),
      .o_head  (out_data),
      .o_level (w_level)
   );

   // A same-cycle pop frees a slot, so a full FIFO can still accept.
   always_comb begin
      w_run       = (r_state == RUN);
      w_full      = (w_level == LW'(DEPTH));
      w_pop       = out_valid && out_ready;
      w_push      = w_run && trace_valid && (!w_full || w_pop);
      w_drop      = w_run && trace_valid && w_full && !w_pop;
      w_level_nxt = w_level + LW'(w_push) - LW'(w_pop);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Trap decision uses the post-edge level, so a trap-cycle word is kept.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN: begin
            if (trap) begin
               w_state_nxt = (w_level_nxt == '0) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (w_level_nxt == '0) begin
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = DONE;
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_count != DROP_MAX) begin
            r_drop_count <= r_drop_count + DROP_W'(1);
         end
      end
   end

   assign out_valid  = (w_level != '0);
   assign out_last   = (r_state == DRAIN) && (w_level == LW'(1));
   assign done       = (r_state == DONE);
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;
   assign level      = w_level;

endmodule

// File: tb/tb_trace_capture.sv
// Directed self-checking bench for trace_capture (DEPTH=16, TW=36).
module tb_trace_capture;

   logic        clk;
   logic        resetn;
   logic        trace_valid;
   logic [35:0] trace_data;
   logic        trap;
   logic        out_valid;
   logic        out_ready;
   logic [35:0] out_data;
   logic        out_last;
   logic        done;
   logic        overflow;
   logic [15:0] drop_count;
   logic [4:0]  level;

   int checks;
   int failures;

   trace_capture #(.DEPTH(16), .TW(36)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .trace_valid (trace_valid),
      .trace_data  (trace_data),
      .trap        (trap),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .done        (done),
      .overflow    (overflow),
      .drop_count  (drop_count),
      .level       (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn      = 1'b0;
      trace_valid = 1'b0;
      trace_data  = '0;
      trap        = 1'b0;
      out_ready   = 1'b0;
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn      = 1'b0;
      trace_valid = 1'b1;
      trace_data  = 36'h1_23456789;
      trap        = 1'b1;
      out_ready   = 1'b1;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL rst_out_last got=%b exp=0", out_last); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
      checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got=%b exp=0", overflow); end
      checks++; if (drop_count !== 16'd0) begin failures++; $display("FAIL rst_drop_count got=%0d exp=0", drop_count); end
      checks++; if (level !== 5'd0) begin failures++; $display("FAIL rst_level got=%0d exp=0", level); end
      trace_valid = 1'b0;
      trap        = 1'b0;
      out_ready   = 1'b0;
      resetn      = 1'b1;
   endtask

   task automatic test_passthrough();
      do_reset();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         trace_valid = 1'b1;
         trace_data  = 36'(i);
         tick();
         checks++; if (out_valid !== 1'b1 || out_data !== 36'(i)) begin
            failures++; $display("FAIL pass_word%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 36'(i));
         end
         checks++; if (level !== 5'd1) begin failures++; $display("FAIL pass_level%0d got=%0d exp=1", i, level); end
      end
      trace_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin
         failures++; $display("FAIL pass_empty got=%b/%0d exp=0/0", out_valid, level);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         trace_valid = 1'b1;
         trace_data  = 36'h100 + 36'(i);
         tick();
      end
      trace_valid = 1'b0;
      checks++; if (level !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", level); end
      checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      checks++; if (drop_count !== 16'd4) begin failures++; $display("FAIL ovf_drop_count got=%0d exp=4", drop_count); end
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++; if (out_valid !== 1'b1 || out_data !== 36'h100 + 36'(i)) begin
            failures++; $display("FAIL ovf_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 36'h100 + 36'(i));
         end
         tick();
      end
      checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL ovf_empty got=%0d/%b exp=0/0", level, out_valid);
      end
      checks++; if (overflow !== 1'b1 || drop_count !== 16'd4) begin
         failures++; $display("FAIL ovf_sticky got=%b/%0d exp=1/4", overflow, drop_count);
      end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         trace_valid = 1'b1;
         trace_data  = 36'h200 + 36'(i);
         tick();
      end
      checks++; if (level !== 5'd16 || overflow !== 1'b0) begin
         failures++; $display("FAIL fullpop_prefill got=%0d/%b exp=16/0", level, overflow);
      end
      trace_data = 36'h2FF;
      out_ready  = 1'b1;
      tick();
      trace_valid = 1'b0;
      checks++; if (level !== 5'd16) begin failures++; $display("FAIL fullpop_level got=%0d exp=16", level); end
      checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin
         failures++; $display("FAIL fullpop_nodrop got=%0d/%b exp=0/0", drop_count, overflow);
      end
      for (int i = 1; i <= 16; i++) begin
         logic [35:0] exp_w;
         exp_w = (i == 16) ? 36'h2FF : 36'h200 + 36'(i);
         checks++; if (out_valid !== 1'b1 || out_data !== exp_w) begin
            failures++; $display("FAIL fullpop_drain%0d got=%b/%h exp=1/%h", i, out_valid, out_data, exp_w);
         end
         tick();
      end
   endtask

   task automatic test_trap_drain();
      logic [35:0] exp_w [4];
      exp_w[0] = 36'h300;
      exp_w[1] = 36'h301;
      exp_w[2] = 36'h302;
      exp_w[3] = 36'hA_DEADBEEF;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         trace_valid = 1'b1;
         trace_data  = exp_w[i];
         tick();
      end
      trap       = 1'b1;
      trace_data = 36'hA_DEADBEEF;
      tick();
      checks++; if (level !== 5'd4 || done !== 1'b0 || out_last !== 1'b0) begin
         failures++; $display("FAIL trap_capture got=%0d/%b/%b exp=4/0/0", level, done, out_last);
      end
      trap       = 1'b0;
      trace_data = 36'h999;
      tick();
      tick();
      trace_valid = 1'b0;
      checks++; if (level !== 5'd4) begin failures++; $display("FAIL trap_refuse_level got=%0d exp=4", level); end
      checks++; if (drop_count !== 16'd0 || overflow !== 1'b0) begin
         failures++; $display("FAIL trap_refuse_nodrop got=%0d/%b exp=0/0", drop_count, overflow);
      end
      trap      = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (out_data !== exp_w[i] || out_last !== (i == 3) || done !== 1'b0) begin
            failures++; $display("FAIL trap_drain%0d got=%h/%b/%b exp=%h/%b/0", i, out_data, out_last, done, exp_w[i], (i == 3));
         end
         tick();
      end
      checks++; if (done !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
         failures++; $display("FAIL trap_done got=%b/%b/%b exp=1/0/0", done, out_valid, out_last);
      end
      trap = 1'b0;
      tick();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL trap_done_hold got=%b exp=1", done); end
      out_ready = 1'b0;
   endtask

   task automatic test_trap_empty();
      do_reset();
      trap = 1'b1;
      tick();
      trap = 1'b0;
      checks++; if (done !== 1'b1 || out_last !== 1'b0 || level !== 5'd0) begin
         failures++; $display("FAIL empty_trap got=%b/%b/%0d exp=1/0/0", done, out_last, level);
      end
      trace_valid = 1'b1;
      trace_data  = 36'h777;
      tick();
      trace_valid = 1'b0;
      checks++; if (level !== 5'd0 || done !== 1'b1 || drop_count !== 16'd0 || out_last !== 1'b0) begin
         failures++; $display("FAIL empty_done_refuse got=%0d/%b/%0d/%b exp=0/1/0/0", level, done, drop_count, out_last);
      end
   endtask

   task automatic test_reset_mid_drain();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         trace_valid = 1'b1;
         trace_data  = 36'h400 + 36'(i);
         trap        = (i == 4);
         tick();
      end
      trace_valid = 1'b0;
      trap        = 1'b0;
      checks++; if (level !== 5'd5 || done !== 1'b0) begin
         failures++; $display("FAIL rmd_pre got=%0d/%b exp=5/0", level, done);
      end
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      checks++; if (level !== 5'd0 || out_valid !== 1'b0 || done !== 1'b0 || overflow !== 1'b0 || out_last !== 1'b0) begin
         failures++; $display("FAIL rmd_cleared got=%0d/%b/%b/%b/%b exp=0/0/0/0/0", level, out_valid, done, overflow, out_last);
      end
      trace_valid = 1'b1;
      trace_data  = 36'h555;
      tick();
      trace_valid = 1'b0;
      checks++; if (level !== 5'd1 || out_data !== 36'h555 || done !== 1'b0) begin
         failures++; $display("FAIL rmd_accept got=%0d/%h/%b exp=1/555/0", level, out_data, done);
      end
      trap      = 1'b1;
      out_ready = 1'b1;
      tick();
      trap      = 1'b0;
      out_ready = 1'b0;
      checks++; if (done !== 1'b1 || level !== 5'd0) begin
         failures++; $display("FAIL rmd_run_trap got=%b/%0d exp=1/0", done, level);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      resetn      = 1'b0;
      trace_valid = 1'b0;
      trace_data  = '0;
      trap        = 1'b0;
      out_ready   = 1'b0;
      test_reset();
      test_passthrough();
      test_overflow();
      test_full_pop();
      test_trap_drain();
      test_trap_empty();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
